// File: rtl/float_ci_pkg.sv
// Shared types and constants for the s2_* floating-point custom-instruction responder.
package float_ci_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned MAN_W    = 48;
  localparam int unsigned LZ_W     = 6;
  localparam int unsigned EXP_W    = 11;
  localparam int unsigned EXP_BIAS = 127;

  typedef enum logic [2:0] {
    FMUL = 3'd0,
    I2F  = 3'd1,
    F2I  = 3'd2
  } ci_op_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    UNPACK = 3'd1,
    EXEC   = 3'd2,
    NORM   = 3'd3,
    PACK   = 3'd4
  } ci_state_t;

  localparam logic [DATA_W-1:0] QNAN    = 32'h7FC0_0000;
  localparam logic [DATA_W-1:0] POS_INF = 32'h7F80_0000;
  localparam logic [DATA_W-1:0] NEG_INF = 32'hFF80_0000;
  localparam logic [DATA_W-1:0] INT_MAX = 32'h7FFF_FFFF;
  localparam logic [DATA_W-1:0] INT_MIN = 32'h8000_0000;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] man;
  } fp_fields_t;

endpackage

// File: rtl/float_ci_unit_fp_normalize.sv
// Leading-zero count and left shift of a 48-bit mantissa, with guard/round/sticky below a 24-bit result.
module fp_normalize
  import float_ci_pkg::*;
(
  input  logic [MAN_W-1:0] man_i,
  output logic [LZ_W-1:0]  lz_o,
  output logic [MAN_W-1:0] man_o,
  output logic             guard_o,
  output logic             round_o,
  output logic             sticky_o
);

  // Highest set bit wins; an all-zero input shifts out completely.
  always_comb begin
    lz_o = LZ_W'(MAN_W);
    for (int i = 0; i < int'(MAN_W); i++) begin
      if (man_i[i]) lz_o = LZ_W'(int'(MAN_W) - 1 - i);
    end
  end

  assign man_o    = man_i << lz_o;
  assign guard_o  = man_o[MAN_W-25];
  assign round_o  = man_o[MAN_W-26];
  assign sticky_o = |man_o[MAN_W-27:0];

endmodule

// File: rtl/float_ci_unit.sv
// Multicycle int32->float, float*float and float->int32 responder for one gain FSM's s2_* bus.
module float_ci_unit
  import float_ci_pkg::*;
#(
  parameter int unsigned LATENCY = 4
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              s2_clk_en,
  input  logic              s2_start,
  input  logic [2:0]        s2_n,
  input  logic [DATA_W-1:0] s2_dataa,
  input  logic [DATA_W-1:0] s2_datab,
  output logic              s2_done,
  output logic [DATA_W-1:0] s2_result
);

  // The packing stage is the LATENCY-th stage after IDLE.
  localparam ci_state_t LAST_ST = ci_state_t'(3'(LATENCY));

  ci_state_t         state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
  logic              sign_q, sign_d;
  logic [EXP_W-1:0]  exp_q, exp_d;
  logic [MAN_W-1:0]  mant_q, mant_d;
  logic [23:0]       ma_q, ma_d, mb_q, mb_d;
  logic              spec_q, spec_d;
  logic [DATA_W-1:0] spec_val_q, spec_val_d;
  logic [2:0]        grs_q, grs_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] result_q, result_d;

  fp_fields_t fa, fb;
  assign fa = a_q;
  assign fb = b_q;

  logic              a_nan, a_inf, a_zero, b_nan, b_inf, b_zero;
  logic              fmul_sign, fmul_spec;
  logic [DATA_W-1:0] fmul_spec_val;
  logic [EXP_W-1:0]  fmul_exp;
  logic [DATA_W-1:0] i2f_mag;
  logic [4:0]        f2i_shamt;
  logic [DATA_W-1:0] f2i_mag, f2i_res;

  // Operand classification and the per-opcode setup values consumed in UNPACK.
  always_comb begin
    a_nan  = (fa.exp == 8'hFF) && (fa.man != '0);
    a_inf  = (fa.exp == 8'hFF) && (fa.man == '0);
    a_zero = (fa.exp == 8'h00);
    b_nan  = (fb.exp == 8'hFF) && (fb.man != '0);
    b_inf  = (fb.exp == 8'hFF) && (fb.man == '0);
    b_zero = (fb.exp == 8'h00);

    fmul_sign     = fa.sign ^ fb.sign;
    fmul_exp      = EXP_W'(fa.exp) + EXP_W'(fb.exp) - EXP_W'(EXP_BIAS - 1);
    fmul_spec     = 1'b1;
    fmul_spec_val = '0;
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
      fmul_spec_val = QNAN;
    end else if (a_inf || b_inf) begin
      fmul_spec_val = fmul_sign ? NEG_INF : POS_INF;
    end else if (a_zero || b_zero) begin
      fmul_spec_val = {fmul_sign, 31'b0};
    end else begin
      fmul_spec = 1'b0;
    end

    i2f_mag = a_q[31] ? (~a_q + 32'd1) : a_q;

    f2i_shamt = 5'(fa.exp - 8'(EXP_BIAS));
    if (f2i_shamt >= 5'd23) f2i_mag = 32'({1'b1, fa.man}) << (f2i_shamt - 5'd23);
    else                    f2i_mag = 32'({1'b1, fa.man}) >> (5'd23 - f2i_shamt);

    if (a_nan)                              f2i_res = INT_MIN;
    else if (fa.exp < 8'(EXP_BIAS))         f2i_res = '0;
    else if (fa.exp >= 8'(EXP_BIAS + 31))   f2i_res = fa.sign ? INT_MIN : INT_MAX;
    else                                    f2i_res = fa.sign ? (~f2i_mag + 32'd1) : f2i_mag;
  end

  logic [LZ_W-1:0]  norm_lz;
  logic [MAN_W-1:0] norm_man;
  logic             norm_g, norm_r, norm_s;

  fp_normalize u_norm (
    .man_i    (mant_q),
    .lz_o     (norm_lz),
    .man_o    (norm_man),
    .guard_o  (norm_g),
    .round_o  (norm_r),
    .sticky_o (norm_s)
  );

  logic              round_up, frac_carry;
  logic [22:0]       frac_rnd;
  logic [EXP_W-1:0]  exp_rnd;
  logic [DATA_W-1:0] packed_res;

  // Round to nearest-even on the normalised mantissa, then range-check the exponent.
  always_comb begin
    round_up                 = grs_q[2] & (grs_q[1] | grs_q[0] | mant_q[MAN_W-24]);
    {frac_carry, frac_rnd}   = {1'b0, mant_q[MAN_W-2:MAN_W-24]} + 24'(round_up);
    exp_rnd                  = exp_q + EXP_W'(frac_carry);
    if (!exp_rnd[EXP_W-1] && (exp_rnd >= EXP_W'(255))) begin
      packed_res = sign_q ? NEG_INF : POS_INF;
    end else if (exp_rnd[EXP_W-1] || (exp_rnd == '0)) begin
      packed_res = {sign_q, 31'b0};
    end else begin
      packed_res = {sign_q, exp_rnd[7:0], frac_rnd};
    end
  end

  // Next-state and datapath; everything holds while s2_clk_en is low.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    sign_d     = sign_q;
    exp_d      = exp_q;
    mant_d     = mant_q;
    ma_d       = ma_q;
    mb_d       = mb_q;
    spec_d     = spec_q;
    spec_val_d = spec_val_q;
    grs_d      = grs_q;
    done_d     = done_q;
    result_d   = result_q;
    if (s2_clk_en) begin
      done_d = 1'b0;
      unique case (state_q)
        IDLE: begin
          if (s2_start) begin
            state_d = UNPACK;
            op_d    = s2_n;
            a_d     = s2_dataa;
            b_d     = s2_datab;
          end
        end
        UNPACK: begin
          state_d    = EXEC;
          spec_d     = 1'b1;
          spec_val_d = '0;
          sign_d     = 1'b0;
          exp_d      = '0;
          mant_d     = '0;
          ma_d       = {1'b1, fa.man};
          mb_d       = {1'b1, fb.man};
          if (op_q == FMUL) begin
            spec_d     = fmul_spec;
            spec_val_d = fmul_spec_val;
            sign_d     = fmul_sign;
            exp_d      = fmul_exp;
          end else if (op_q == I2F) begin
            spec_d = (a_q == '0);
            sign_d = a_q[31];
            exp_d  = EXP_W'(EXP_BIAS + 31);
            mant_d = {i2f_mag, 16'b0};
          end else if (op_q == F2I) begin
            spec_val_d = f2i_res;
          end
        end
        EXEC: begin
          state_d = NORM;
          if (op_q == FMUL) mant_d = MAN_W'(ma_q) * MAN_W'(mb_q);
        end
        NORM: begin
          state_d = LAST_ST;
          mant_d  = norm_man;
          exp_d   = exp_q - EXP_W'(norm_lz);
          grs_d   = {norm_g, norm_r, norm_s};
        end
        LAST_ST: begin
          state_d  = IDLE;
          done_d   = 1'b1;
          result_d = spec_q ? spec_val_q : packed_res;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= IDLE;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      sign_q     <= 1'b0;
      exp_q      <= '0;
      mant_q     <= '0;
      ma_q       <= '0;
      mb_q       <= '0;
      spec_q     <= 1'b0;
      spec_val_q <= '0;
      grs_q      <= '0;
      done_q     <= 1'b0;
      result_q   <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      sign_q     <= sign_d;
      exp_q      <= exp_d;
      mant_q     <= mant_d;
      ma_q       <= ma_d;
      mb_q       <= mb_d;
      spec_q     <= spec_d;
      spec_val_q <= spec_val_d;
      grs_q      <= grs_d;
      done_q     <= done_d;
      result_q   <= result_d;
    end
  end

  assign s2_done   = done_q;
  assign s2_result = result_q;

endmodule

// File: tb/tb_float_ci_unit.sv
// Directed, table-driven bench for float_ci_unit plus handshake corner sequences.
module tb_float_ci_unit;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        s2_clk_en;
  logic        s2_start;
  logic [2:0]  s2_n;
  logic [31:0] s2_dataa;
  logic [31:0] s2_datab;
  logic        s2_done;
  logic [31:0] s2_result;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 CLK = ~CLK;

  float_ci_unit #(.LATENCY(4)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .s2_clk_en (s2_clk_en),
    .s2_start  (s2_start),
    .s2_n      (s2_n),
    .s2_dataa  (s2_dataa),
    .s2_datab  (s2_datab),
    .s2_done   (s2_done),
    .s2_result (s2_result)
  );

  typedef struct {
    logic [2:0]  n;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
  } vec_t;

  localparam int NVEC = 23;
  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Drive a start at the falling edge; returns just after the accepting rising edge.
  task automatic start_op(input logic [2:0] n, input logic [31:0] a, input logic [31:0] b);
    @(negedge CLK);
    s2_start = 1'b1;
    s2_n     = n;
    s2_dataa = a;
    s2_datab = b;
    @(posedge CLK);
    #1;
    s2_start = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc, output int cyc);
    cyc = 0;
    for (int i = 1; i <= max_cyc && cyc == 0; i++) begin
      @(posedge CLK);
      #1;
      if (s2_done) cyc = i;
    end
  endtask

  task automatic run_op(input string name, input logic [2:0] n, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
    int cyc;
    start_op(n, a, b);
    wait_done(12, cyc);
    check({name, "_latency"}, 32'(cyc), 32'd4);
    check({name, "_result"}, s2_result, exp);
    @(posedge CLK);
    #1;
    check({name, "_pulse"}, 32'(s2_done), 32'd0);
  endtask

  initial begin
    int cyc;
    int cnt;
    int first;
    logic [31:0] res_seen;

    vecs[0]  = '{3'd1, 32'h0000_03E8, 32'hDEAD_BEEF, 32'h447A_0000};
    vecs[1]  = '{3'd0, 32'h447A_0000, 32'h4120_0000, 32'h461C_4000};
    vecs[2]  = '{3'd2, 32'h461C_4000, 32'h0000_0000, 32'h0000_2710};
    vecs[3]  = '{3'd2, 32'hC030_0000, 32'h1234_5678, 32'hFFFF_FFFE};
    vecs[4]  = '{3'd2, 32'h4F00_0000, 32'h0000_0000, 32'h7FFF_FFFF};
    vecs[5]  = '{3'd2, 32'h7FC0_0000, 32'h0000_0000, 32'h8000_0000};
    vecs[6]  = '{3'd2, 32'h3F00_0000, 32'h0000_0000, 32'h0000_0000};
    vecs[7]  = '{3'd0, 32'h7F00_0000, 32'h4000_0000, 32'h7F80_0000};
    vecs[8]  = '{3'd0, 32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000};
    vecs[9]  = '{3'd0, 32'h0040_0000, 32'h4000_0000, 32'h0000_0000};
    vecs[10] = '{3'd0, 32'hBF80_0000, 32'h3F80_0000, 32'hBF80_0000};
    vecs[11] = '{3'd5, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0000_0000};
    vecs[12] = '{3'd1, 32'h8000_0000, 32'h0000_0000, 32'hCF00_0000};
    vecs[13] = '{3'd1, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000};
    vecs[14] = '{3'd1, 32'hFFFF_FFFF, 32'h0000_0000, 32'hBF80_0000};
    vecs[15] = '{3'd1, 32'h0100_0001, 32'h0000_0000, 32'h4B80_0000};
    vecs[16] = '{3'd1, 32'h0100_0003, 32'h0000_0000, 32'h4B80_0002};
    vecs[17] = '{3'd0, 32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000};
    vecs[18] = '{3'd2, 32'hCF00_0000, 32'h0000_0000, 32'h8000_0000};
    vecs[19] = '{3'd2, 32'hFF80_0000, 32'h0000_0000, 32'h8000_0000};
    vecs[20] = '{3'd2, 32'h7F80_0000, 32'h0000_0000, 32'h7FFF_FFFF};
    vecs[21] = '{3'd0, 32'h0080_0000, 32'h0080_0000, 32'h0000_0000};
    vecs[22] = '{3'd0, 32'h3F80_0001, 32'h3F80_0001, 32'h3F80_0002};

    RESET     = 1'b1;
    s2_clk_en = 1'b1;
    s2_start  = 1'b0;
    s2_n      = 3'd0;
    s2_dataa  = '0;
    s2_datab  = '0;
    repeat (3) @(posedge CLK);
    #1;
    check("reset_done", 32'(s2_done), 32'd0);
    check("reset_result", s2_result, 32'h0);
    @(negedge CLK);
    RESET = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].n, vecs[i].a, vecs[i].b, vecs[i].res);
    end

    // A start two cycles into an operation must be ignored.
    start_op(3'd1, 32'h0000_03E8, 32'h0);
    @(negedge CLK);
    @(negedge CLK);
    s2_start = 1'b1;
    s2_n     = 3'd0;
    s2_dataa = 32'h4000_0000;
    s2_datab = 32'h4000_0000;
    @(posedge CLK);
    #1;
    s2_start = 1'b0;
    cnt      = 0;
    first    = 0;
    res_seen = '0;
    for (int i = 1; i <= 12; i++) begin
      @(posedge CLK);
      #1;
      if (s2_done) begin
        cnt++;
        if (first == 0) begin
          first    = i;
          res_seen = s2_result;
        end
      end
    end
    check("busy_done_count", 32'(cnt), 32'd1);
    check("busy_done_time", 32'(first), 32'd2);
    check("busy_result", res_seen, 32'h447A_0000);

    // Back-to-back: start accepted in the done cycle, previous result held meanwhile.
    start_op(3'd0, 32'h3FC0_0000, 32'h3FC0_0000);
    wait_done(12, cyc);
    check("b2b_first_latency", 32'(cyc), 32'd4);
    check("b2b_first_result", s2_result, 32'h4010_0000);
    start_op(3'd1, 32'hFFFF_FFFF, 32'h0);
    check("b2b_done_dropped", 32'(s2_done), 32'd0);
    check("b2b_result_held", s2_result, 32'h4010_0000);
    wait_done(12, cyc);
    check("b2b_second_latency", 32'(cyc + 1), 32'd5);
    check("b2b_second_result", s2_result, 32'hBF80_0000);

    // Clock enable low for three cycles stretches the latency.
    start_op(3'd2, 32'hC030_0000, 32'h0);
    @(negedge CLK);
    s2_clk_en = 1'b0;
    repeat (3) @(negedge CLK);
    s2_clk_en = 1'b1;
    wait_done(12, cyc);
    check("clken_latency", 32'(cyc + 3), 32'd7);
    check("clken_result", s2_result, 32'hFFFF_FFFE);
    @(negedge CLK);
    s2_clk_en = 1'b0;
    @(posedge CLK);
    #1;
    check("clken_done_hold1", 32'(s2_done), 32'd1);
    @(posedge CLK);
    #1;
    check("clken_done_hold2", 32'(s2_done), 32'd1);
    @(negedge CLK);
    s2_clk_en = 1'b1;
    @(posedge CLK);
    #1;
    check("clken_done_release", 32'(s2_done), 32'd0);

    // Reset two cycles after accept aborts; start held through reset only takes after it.
    start_op(3'd0, 32'h447A_0000, 32'h4120_0000);
    @(negedge CLK);
    @(negedge CLK);
    RESET    = 1'b1;
    s2_start = 1'b1;
    s2_n     = 3'd1;
    s2_dataa = 32'h0000_0007;
    s2_datab = 32'h0;
    @(posedge CLK);
    #1;
    check("rst_mid_done", 32'(s2_done), 32'd0);
    check("rst_mid_result", s2_result, 32'h0);
    @(negedge CLK);
    RESET = 1'b0;
    @(posedge CLK);
    #1;
    s2_start = 1'b0;
    check("rst_after_done", 32'(s2_done), 32'd0);
    wait_done(12, cyc);
    check("rst_new_latency", 32'(cyc), 32'd4);
    check("rst_new_result", s2_result, 32'h40E0_0000);

    repeat (2) @(posedge CLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/float_ci_unit.md
# float_ci_unit

In-house responder for the `s2_*` multicycle floating-point custom-instruction handshake that the per-channel gain FSMs drive. It accepts one operation per `s2_start` and computes one of three operations: int32→float, float×float, or float→int32. It then returns the result with a single-cycle `s2_done` pulse. It drops in wherever a gain FSM's `s2_*` bus is connected, one instance per audio channel.

## Interface
Parameters:
- `LATENCY`, default 4: cycles from accepted `s2_start` to `s2_done`. This is fixed and equals the FSM depth; no other value is supported.

Ports:
- `CLK` in 1: system clock; all logic is on the rising edge.
- `RESET` in 1: synchronous, active-high reset.
- `s2_clk_en` in 1: when low, all state and outputs hold.
- `s2_start` in 1: request strobe, sampled while idle.
- `s2_n` in 3: opcode. 0 = FMUL, 1 = I2F, 2 = F2I, 3–7 = reserved.
- `s2_dataa` in 32: operand A. Float (IEEE-754 single) or signed int32, depending on opcode.
- `s2_datab` in 32: operand B, used by FMUL only.
- `s2_done` out 1: one-cycle completion pulse.
- `s2_result` out 32: result. Valid while `s2_done` is high; held until the next completion.

## Operation
- States: IDLE → UNPACK → EXEC → NORM → PACK → IDLE.
  - `s2_done` and `s2_result` are registered on the PACK→IDLE edge.
  - Operands and opcode are captured on the edge that accepts `s2_start`.
- Acceptance: `s2_start`=1, state is IDLE, and `s2_clk_en`=1. A start while busy is ignored; it is neither queued nor allowed to corrupt the operation in flight.
- FMUL:
  - Sign is the XOR of the operand signs.
  - The 24×24 mantissa product is normalised, then rounded to nearest-even.
  - Subnormal inputs are flushed to signed zero. Underflow produces signed zero.
  - Overflow and any finite×inf produce signed infinity.
  - A NaN operand or inf×0 produces 0x7FC00000.
- I2F:
  - Two's-complement magnitude, then leading-zero normalise, then round to nearest-even.
  - 0 → 0x00000000. 0x80000000 → 0xCF000000.
- F2I:
  - Truncates toward zero. |x|<1 and subnormals → 0.
  - Values ≥ 2^31 and +inf → 0x7FFFFFFF. Values < −2^31 and −inf → 0x80000000. NaN → 0x80000000.
- Reserved opcode: the full latency is still run; the result is 0x00000000 and `s2_done` pulses.
- `s2_datab` is ignored for I2F and F2I.

## Timing
- Start accepted at edge k → `s2_done`=1 during the cycle after edge k+4. The earliest next accept is that same done cycle, so one operation completes every 5 cycles.
- `s2_done` is high for exactly one enabled cycle.
- `s2_clk_en` low stretches the latency by the number of disabled cycles. If `s2_done` is already asserted, it stays high until the next enabled edge.
- Reset values: state = IDLE, `s2_done` = 0, `s2_result` = 0x00000000.
- Reset mid-operation aborts the operation; no `s2_done` follows. RESET has priority over a simultaneous `s2_start`.
- Start in the same cycle as `s2_done` is accepted. The previous result stays on `s2_result` until the new completion.

## Structure
- `float_ci_pkg` contains:
  - opcode enum `ci_op_t` (FMUL, I2F, F2I);
  - state enum;
  - constants `QNAN`=0x7FC00000, `POS_INF`, `NEG_INF`, `INT_MAX`, `INT_MIN`, exponent bias 127;
  - a packed struct `fp_fields_t` {sign, exp[7:0], man[22:0]}.
- Sub-module `fp_normalize`: a combinational leading-zero count plus left shift on a 48-bit mantissa, with guard/round/sticky extraction. It is shared by the FMUL and I2F paths and instantiated once.

## Test plan
- I2F with `s2_dataa`=1000 (0x000003E8) → `s2_result`=0x447A0000 and `s2_done` pulses exactly 5 cycles after the start cycle. Then FMUL 0x447A0000 × 0x41200000 → 0x461C4000, then F2I 0x461C4000 → 0x00002710. This covers the full gain round trip.
- F2I edge cases:
  - 0xC0300000 (−2.75) → 0xFFFFFFFE
  - 0x4F000000 → 0x7FFFFFFF
  - 0x7FC00000 → 0x80000000
  - 0x3F000000 → 0x00000000
- FMUL specials:
  - 0x7F000000 × 0x40000000 → 0x7F800000
  - 0x7F800000 × 0x00000000 → 0x7FC00000
  - 0x00400000 × 0x40000000 → 0x00000000
  - 0xBF800000 × 0x3F800000 → 0xBF800000
- Handshake:
  - Pulse `s2_start` again 2 cycles after an accept, with different operands → the first result is unaffected and only one `s2_done` occurs.
  - Back-to-back start on the done cycle → the second done arrives 5 cycles later.
- `s2_clk_en` held low for 3 cycles mid-operation → `s2_done` arrives 3 cycles late with the correct value.
- RESET asserted 2 cycles after an accept → no `s2_done`, `s2_result`=0, and a new start is accepted on the cycle after reset deasserts.
- Reserved opcode 5 → `s2_result`=0x00000000 with a normal-latency `s2_done`.
